opstack_client: RTL and testbench
=================================

# opstack_client

Requester-side sequencer for the 32-bit operand stack: accepts one stack command at a time (push, pop, pop2, dup, swap), breaks it into single push/pop accesses on the stack's `trigger`/`push`/`done` interface, and returns popped operands on a response pulse. Sits between the bytecode execute stage and the operand-stack memory block, so execute logic never handles stack access timing.

## Interface
- `DEPTH`, 65536: stack capacity in words; used only by the depth check.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; command accepted on `cmd_valid && cmd_ready`.
- `cmd_op` in 3: 0 PUSH, 1 POP, 2 POP2, 3 DUP, 4 SWAP; 5–7 reserved.
- `cmd_data` in 32: PUSH value; ignored otherwise.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_a` out 32: first popped word (top of stack).
- `rsp_b` out 32: second popped word (POP2/SWAP).
- `rsp_err` out 1: qualifies `rsp_valid`; command rejected, no stack access made.
- `stk_trigger` out 1: one-cycle access strobe to the stack.
- `stk_push` out 1: 1 push, 0 pop; valid with `stk_trigger`.
- `stk_write_value` out 32: push data; valid with `stk_trigger`.
- `stk_read_value` in 32: pop data; sampled in the cycle `stk_done` is high.
- `stk_done` in 1: access completion pulse from the stack.

## Operation
- Reset values: `cmd_ready` 1, `rsp_valid` 0, `rsp_err` 0, `rsp_a`/`rsp_b` 0, `stk_trigger` 0, `stk_push` 0, `stk_write_value` 0; state IDLE; step 0; depth 0.
- States: IDLE → ISSUE → WAIT → (ISSUE | RESP) → IDLE.
- IDLE: on accept, latch op and data, clear step → ISSUE (or RESP with `rsp_err` if rejected).
- ISSUE: drive `stk_trigger` high exactly one cycle with the step's push/pop and data → WAIT.
- WAIT: hold `stk_trigger` low; on `stk_done`, capture `stk_read_value` for pop steps and advance step; more steps → ISSUE, else → RESP.
- RESP: `rsp_valid` high one cycle → IDLE.
- Micro-sequences (A, B are internal temporaries):
  - PUSH: push data.
  - POP: pop → A.
  - POP2: pop → A, pop → B.
  - DUP: pop → A, push A, push A.
  - SWAP: pop → A, pop → B, push A, push B.
- `rsp_a` = A, `rsp_b` = B. Both hold until overwritten by the next command. For PUSH, DUP and SWAP they report the values popped, if any.
- Reserved op: rejected with `rsp_err`.
- `stk_done` outside WAIT is ignored.
- Asynchronous reset mid-command returns all outputs to reset values immediately. The stack itself has no reset, so software must treat the stack as empty afterwards.

## Timing
- Accept at cycle 0. First `stk_trigger` at cycle 1. Stack `stk_done` arrives 2 cycles after each trigger. Next trigger follows 1 cycle after `stk_done`.
- For N accesses, `rsp_valid` is at cycle 3N+1: PUSH/POP 4, POP2 7, DUP 10, SWAP 13.
- Rejected command: `rsp_valid` at cycle 1, with zero triggers.
- `cmd_ready` is low from the accept edge through the RESP cycle, then high again in the cycle after RESP.
- Busy is unbounded: if `stk_done` never arrives, the block stays in WAIT.

## Configuration
- `OPSTACK_DEPTH_CHECK_EN` defined:
  - A 17-bit depth counter tracks net pushes.
  - A command is rejected (`rsp_err`) if it needs more pops than the current depth: POP/DUP need depth ≥ 1, POP2/SWAP need depth ≥ 2.
  - It is also rejected if the net growth would exceed `DEPTH`: PUSH and DUP need depth < `DEPTH`.
  - The counter updates per completed access.
- Not defined: no counter, no range checks. `rsp_err` is set only for reserved ops.

## Structure
- Package `opstack_pkg` holds:
  - `opstack_op_t` enum (PUSH..SWAP).
  - `opstack_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - Per-op access count and required-depth constants.
- Sub-module `opstack_ucode`: combinational decode of (op, step) to {is_push, push_src A/B/data, is_last}.

## Test plan
- PUSH 0xDEADBEEF then POP → one trigger with `stk_push`=1 and data 0xDEADBEEF; POP gives `rsp_a`=0xDEADBEEF, `rsp_valid` at cycle 4 after accept.
- PUSH 1, PUSH 2, SWAP, POP2 → SWAP `rsp_a`=2, `rsp_b`=1; POP2 `rsp_a`=1, `rsp_b`=2; `rsp_valid` at cycle 13 and 7 respectively.
- PUSH 7, DUP, POP2 → `rsp_a`=7, `rsp_b`=7; exactly 3 triggers seen for DUP.
- With `OPSTACK_DEPTH_CHECK_EN`, POP on empty → `rsp_err`=1 at cycle 1, no `stk_trigger`. PUSH 5 then POP2 → `rsp_err`=1.
- `cmd_op`=6 → `rsp_err`=1, stack untouched. `cmd_valid` held high during a SWAP is not accepted until `cmd_ready` returns.
- `rst_n` low while in WAIT during SWAP → outputs at reset values same cycle; after release `cmd_ready`=1, and POP with the check enabled gives `rsp_err`.

Source files
------------

// File: rtl/opstack_pkg.sv
// Shared types for the operand-stack client: opcodes, FSM states, push sources
// and the per-op access-count / required-depth tables.
package opstack_pkg;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_POP2 = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4
    } opstack_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } opstack_state_t;

    typedef enum logic [1:0] {
        SRC_DATA,
        SRC_A,
        SRC_B
    } push_src_t;

    localparam int DEPTH_W = 17;

    function automatic logic op_is_valid(input logic [2:0] op);
        return op inside {OP_PUSH, OP_POP, OP_POP2, OP_DUP, OP_SWAP};
    endfunction

    // Number of single stack accesses making up each command.
    function automatic logic [2:0] op_accesses(input logic [2:0] op);
        case (op)
            OP_PUSH: return 3'd1;
            OP_POP:  return 3'd1;
            OP_POP2: return 3'd2;
            OP_DUP:  return 3'd3;
            OP_SWAP: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Minimum stack depth before the command may start popping.
    function automatic logic [DEPTH_W-1:0] op_min_depth(input logic [2:0] op);
        case (op)
            OP_POP, OP_DUP:   return DEPTH_W'(1);
            OP_POP2, OP_SWAP: return DEPTH_W'(2);
            default:          return DEPTH_W'(0);
        endcase
    endfunction

    // Commands that leave the stack one word deeper.
    function automatic logic op_grows(input logic [2:0] op);
        return op inside {OP_PUSH, OP_DUP};
    endfunction

endpackage

// File: rtl/opstack_ucode.sv
// Micro-sequence decode: maps (command, step) to the single push/pop access
// performed in that step, where push data comes from, and whether it is the last.
module opstack_ucode
    import opstack_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [1:0] step_i,
    output logic       is_push_o,
    output push_src_t  push_src_o,
    output logic       is_last_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        is_push_o  = 1'b0;
        push_src_o = SRC_DATA;
        is_last_o  = ({1'b0, step_i} + 3'd1) == op_accesses(op_i);
        case (op_i)
            OP_PUSH: is_push_o = 1'b1;
            OP_DUP: begin
                is_push_o  = (step_i != 2'd0);
                push_src_o = SRC_A;
            end
            OP_SWAP: begin
                is_push_o  = step_i[1];
                push_src_o = step_i[0] ? SRC_B : SRC_A;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/opstack_client.sv
// Operand-stack requester: turns one command into single push/pop accesses.
// Define OPSTACK_DEPTH_CHECK_EN to track depth and reject under/overflowing commands.
module opstack_client
    import opstack_pkg::*;
#(
    parameter int unsigned DEPTH = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_a,
    output logic [31:0] rsp_b,
    output logic        rsp_err,
    output logic        stk_trigger,
    output logic        stk_push,
    output logic [31:0] stk_write_value,
    input  logic [31:0] stk_read_value,
    input  logic        stk_done
);

    opstack_state_t state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [31:0]    data_q, data_d;
    logic [1:0]     step_q, step_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic           err_q, err_d;
    logic           reject;

    logic           uc_is_push;
    push_src_t      uc_push_src;
    logic           uc_is_last;

    opstack_ucode u_ucode (
        .op_i       (op_q),
        .step_i     (step_q),
        .is_push_o  (uc_is_push),
        .push_src_o (uc_push_src),
        .is_last_o  (uc_is_last)
    );

    wire access_done = (state_q == ST_WAIT) && stk_done;

`ifdef OPSTACK_DEPTH_CHECK_EN
    logic [DEPTH_W-1:0] depth_q, depth_d;

    assign reject = !op_is_valid(cmd_op)
                  || (depth_q < op_min_depth(cmd_op))
                  || (op_grows(cmd_op) && (32'(depth_q) >= DEPTH));

    always_comb begin
        depth_d = depth_q;
        if (access_done) begin
            depth_d = uc_is_push ? depth_q + DEPTH_W'(1) : depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end
`else
    assign reject = !op_is_valid(cmd_op);

    // DEPTH only matters to the depth check; keep it referenced in this build.
    logic unused_depth;
    assign unused_depth = |DEPTH;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    step_d  = 2'd0;
                    err_d   = reject;
                    state_d = reject ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (stk_done) begin
                    // First pop of any sequence lands in A, the second in B.
                    if (!uc_is_push) begin
                        if (step_q == 2'd0) a_d = stk_read_value;
                        else                b_d = stk_read_value;
                    end
                    step_d  = step_q + 2'd1;
                    state_d = uc_is_last ? ST_RESP : ST_ISSUE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_a       = a_q;
    assign rsp_b       = b_q;
    assign stk_trigger = (state_q == ST_ISSUE);
    assign stk_push    = stk_trigger && uc_is_push;

    always_comb begin
        stk_write_value = '0;
        if (stk_push) begin
            case (uc_push_src)
                SRC_A:   stk_write_value = a_q;
                SRC_B:   stk_write_value = b_q;
                default: stk_write_value = data_q;
            endcase
        end
    end

endmodule

// File: tb/tb_opstack_client.sv
// Self-checking bench for opstack_client: directed vector table, multi-cycle corner
// sequences and random commands checked against a queue-based stack model.
module tb_opstack_client;

    localparam int TB_DEPTH = 8;
    localparam int NVEC     = 12;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_a;
    logic [31:0] rsp_b;
    logic        rsp_err;
    logic        stk_trigger;
    logic        stk_push;
    logic [31:0] stk_write_value;
    logic [31:0] stk_read_value;
    logic        stk_done;

    opstack_client #(.DEPTH(TB_DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_a           (rsp_a),
        .rsp_b           (rsp_b),
        .rsp_err         (rsp_err),
        .stk_trigger     (stk_trigger),
        .stk_push        (stk_push),
        .stk_write_value (stk_write_value),
        .stk_read_value  (stk_read_value),
        .stk_done        (stk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem[$];
    logic [31:0] ref_stk[$];
    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    logic        inject_stray = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          trig;
    } vec_t;

    vec_t tbl[NVEC];

    // Stack memory: answers each trigger with stk_done two cycles later.
    initial begin : stack_memory
        int          pend;
        logic [31:0] pend_val;
        pend           = 0;
        pend_val       = '0;
        stk_done       = 1'b0;
        stk_read_value = '0;
        forever begin
            @(negedge clk);
            stk_done       = 1'b0;
            stk_read_value = $urandom;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        stk_done       = 1'b1;
                        stk_read_value = pend_val;
                    end
                end else if (inject_stray) begin
                    stk_done     = 1'b1;
                    inject_stray = 1'b0;
                end
                if (stk_trigger) begin
                    if (stk_push)            mem.push_back(stk_write_value);
                    else if (mem.size() > 0) pend_val = mem.pop_back();
                    else                     pend_val = 32'hBAD0BAD0;
                    pend = 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int need_of(input logic [2:0] op);
        case (op)
            3'd1, 3'd3: return 1;
            3'd2, 3'd4: return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic logic grows_of(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd3);
    endfunction

    // Command semantics on a plain queue (back = top of stack).
    task automatic model_cmd(input logic [2:0] op, input logic [31:0] data,
                             output logic err, output int n);
        logic [31:0] x;
        logic [31:0] y;
        err = (op > 3'd4);
        n   = 0;
`ifdef OPSTACK_DEPTH_CHECK_EN
        if (!err && (ref_stk.size() < need_of(op) ||
                     (grows_of(op) && ref_stk.size() >= TB_DEPTH)))
            err = 1'b1;
`endif
        if (!err) begin
            case (op)
                3'd0: begin ref_stk.push_back(data); n = 1; end
                3'd1: begin exp_a = ref_stk.pop_back(); n = 1; end
                3'd2: begin exp_a = ref_stk.pop_back(); exp_b = ref_stk.pop_back(); n = 2; end
                3'd3: begin
                    x = ref_stk.pop_back();
                    exp_a = x;
                    ref_stk.push_back(x);
                    ref_stk.push_back(x);
                    n = 3;
                end
                default: begin
                    x = ref_stk.pop_back();
                    y = ref_stk.pop_back();
                    exp_a = x;
                    exp_b = y;
                    ref_stk.push_back(x);
                    ref_stk.push_back(y);
                    n = 4;
                end
            endcase
        end
    endtask

    // Issue one command from a negedge and measure it; returns at the negedge after RESP.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] data,
                          output logic err, output logic [31:0] a, output logic [31:0] b,
                          output int lat, output int trig);
        int k;
        int busy_ready;
        lat = -1; trig = 0; err = 1'b0; a = '0; b = '0;
        k = 0; busy_ready = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 64'd0, 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = $urandom;
        for (int c = 1; c <= 100; c++) begin
            if (stk_trigger) trig++;
            if (cmd_ready) busy_ready++;
            if (rsp_valid) begin
                lat = c; err = rsp_err; a = rsp_a; b = rsp_b;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            check("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        check("busy_ready_low", 64'(busy_ready), 64'd0);
        @(negedge clk);
        check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        check("ready_after_rsp", 64'(cmd_ready), 64'd1);
    endtask

    task automatic check_stack(input string tag);
        int bad;
        bad = 0;
        check({tag, "_stack_size"}, 64'(mem.size()), 64'(ref_stk.size()));
        if (mem.size() == ref_stk.size()) begin
            foreach (mem[i]) if (mem[i] !== ref_stk[i]) bad++;
        end else begin
            bad = 1;
        end
        check({tag, "_stack_data"}, 64'(bad), 64'd0);
    endtask

    task automatic check_cmd(input string tag, input logic [2:0] op, input logic [31:0] data,
                             output logic err_o);
        logic        m_err;
        int          m_n;
        int          d_lat;
        int          d_trig;
        logic [31:0] d_a;
        logic [31:0] d_b;
        model_cmd(op, data, m_err, m_n);
        do_cmd(op, data, err_o, d_a, d_b, d_lat, d_trig);
        check({tag, "_lat"},  64'(d_lat),  64'(m_err ? 1 : 3 * m_n + 1));
        check({tag, "_trig"}, 64'(d_trig), 64'(m_err ? 0 : m_n));
        check({tag, "_err"},  64'(err_o),  64'(m_err));
        check({tag, "_a"},    64'(d_a),    64'(exp_a));
        check({tag, "_b"},    64'(d_b),    64'(exp_b));
        check_stack(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},   64'(cmd_ready),       64'd1);
        check({tag, "_rsp_valid"},   64'(rsp_valid),       64'd0);
        check({tag, "_rsp_err"},     64'(rsp_err),         64'd0);
        check({tag, "_rsp_a"},       64'(rsp_a),           64'd0);
        check({tag, "_rsp_b"},       64'(rsp_b),           64'd0);
        check({tag, "_stk_trigger"}, 64'(stk_trigger),     64'd0);
        check({tag, "_stk_push"},    64'(stk_push),        64'd0);
        check({tag, "_stk_wdata"},   64'(stk_write_value), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic        m_err;
        int          m_n;
        logic        d_err;
        logic [31:0] d_a;
        logic [31:0] d_b;
        int          d_lat;
        int          d_trig;
        logic [31:0] sa, sb, pa, pb;
        int          first, second, ready_hi, ready_cyc, trig_tot, stray_bad;
        logic [2:0]  op;
        int          r;

        tbl[0]  = '{3'd0, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0, 4,  1};
        tbl[1]  = '{3'd1, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0, 4,  1};
        tbl[2]  = '{3'd0, 32'h1,        1'b0, 32'hDEADBEEF, 32'h0, 4,  1};
        tbl[3]  = '{3'd0, 32'h2,        1'b0, 32'hDEADBEEF, 32'h0, 4,  1};
        tbl[4]  = '{3'd4, 32'h0,        1'b0, 32'h2,        32'h1, 13, 4};
        tbl[5]  = '{3'd2, 32'h0,        1'b0, 32'h1,        32'h2, 7,  2};
        tbl[6]  = '{3'd0, 32'h7,        1'b0, 32'h1,        32'h2, 4,  1};
        tbl[7]  = '{3'd3, 32'h0,        1'b0, 32'h7,        32'h2, 10, 3};
        tbl[8]  = '{3'd2, 32'h0,        1'b0, 32'h7,        32'h7, 7,  2};
        tbl[9]  = '{3'd6, 32'h55,       1'b1, 32'h7,        32'h7, 1,  0};
        tbl[10] = '{3'd5, 32'h66,       1'b1, 32'h7,        32'h7, 1,  0};
        tbl[11] = '{3'd7, 32'h77,       1'b1, 32'h7,        32'h7, 1,  0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            model_cmd(tbl[i].op, tbl[i].data, m_err, m_n);
            do_cmd(tbl[i].op, tbl[i].data, d_err, d_a, d_b, d_lat, d_trig);
            check($sformatf("tbl%0d_lat", i),  64'(d_lat),  64'(tbl[i].lat));
            check($sformatf("tbl%0d_trig", i), 64'(d_trig), 64'(tbl[i].trig));
            check($sformatf("tbl%0d_err", i),  64'(d_err),  64'(tbl[i].err));
            check($sformatf("tbl%0d_a", i),    64'(d_a),    64'(tbl[i].a));
            check($sformatf("tbl%0d_b", i),    64'(d_b),    64'(tbl[i].b));
            check_stack($sformatf("tbl%0d", i));
        end

        // cmd_valid held through a SWAP: next command only taken once ready returns
        check_cmd("hold_push3", 3'd0, 32'h3, d_err);
        check_cmd("hold_push4", 3'd0, 32'h4, d_err);
        model_cmd(3'd4, 32'h0, m_err, m_n);
        sa = exp_a; sb = exp_b;
        model_cmd(3'd2, 32'h0, m_err, m_n);
        pa = exp_a; pb = exp_b;
        first = -1; second = -1; ready_hi = 0; ready_cyc = -1; trig_tot = 0;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = $urandom;
        @(negedge clk);
        cmd_op = 3'd2;
        for (int c = 1; c <= 60; c++) begin
            if (stk_trigger) trig_tot++;
            if (cmd_ready) begin ready_hi++; ready_cyc = c; end
            if (first > 0 && c == first + 2) cmd_valid = 1'b0;
            if (rsp_valid) begin
                if (first < 0) begin
                    first = c;
                    check("hold_swap_trig", 64'(trig_tot), 64'd4);
                    check("hold_swap_a", 64'(rsp_a), 64'(sa));
                    check("hold_swap_b", 64'(rsp_b), 64'(sb));
                end else begin
                    second = c;
                    check("hold_pop2_a", 64'(rsp_a), 64'(pa));
                    check("hold_pop2_b", 64'(rsp_b), 64'(pb));
                    break;
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("hold_swap_lat", 64'(first), 64'd13);
        check("hold_pop2_lat", 64'(second), 64'd21);
        check("hold_trig_total", 64'(trig_tot), 64'd6);
        check("hold_ready_cycles", 64'(ready_hi), 64'd1);
        check("hold_ready_when", 64'(ready_cyc), 64'd14);
        @(negedge clk);
        check("hold_ready_after", 64'(cmd_ready), 64'd1);
        check_stack("hold");

        // stk_done while idle must be ignored
        check_cmd("stray_push", 3'd0, 32'hA5A5_0001, d_err);
        inject_stray = 1'b1;
        stray_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (stk_trigger || rsp_valid || !cmd_ready) stray_bad++;
        end
        check("stray_activity", 64'(stray_bad), 64'd0);
        check("stray_rsp_a", 64'(rsp_a), 64'(exp_a));
        check("stray_rsp_b", 64'(rsp_b), 64'(exp_b));
        check_cmd("stray_pop", 3'd1, 32'h0, d_err);

        // Asynchronous reset while waiting inside a SWAP
        check_cmd("rst_push11", 3'd0, 32'h11, d_err);
        check_cmd("rst_push22", 3'd0, 32'h22, d_err);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_swap_trigger", 64'(stk_trigger), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        mem.delete();
        ref_stk.delete();
        exp_a = '0;
        exp_b = '0;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);

`ifdef OPSTACK_DEPTH_CHECK_EN
        check_cmd("chk_pop_empty", 3'd1, 32'h0, d_err);
        check("chk_pop_empty_rej", 64'(d_err), 64'd1);
        check_cmd("chk_push5", 3'd0, 32'h5, d_err);
        check_cmd("chk_pop2_short", 3'd2, 32'h0, d_err);
        check("chk_pop2_short_rej", 64'(d_err), 64'd1);
        for (int i = 1; i < TB_DEPTH; i++) check_cmd($sformatf("chk_fill%0d", i), 3'd0, $urandom, d_err);
        check_cmd("chk_push_full", 3'd0, 32'hF00D, d_err);
        check("chk_push_full_rej", 64'(d_err), 64'd1);
        check_cmd("chk_dup_full", 3'd3, 32'h0, d_err);
        check("chk_dup_full_rej", 64'(d_err), 64'd1);
        check_cmd("chk_pop_full", 3'd1, 32'h0, d_err);
        check("chk_pop_full_ok", 64'(d_err), 64'd0);
`else
        check_cmd("post_rst_push", 3'd0, 32'h9, d_err);
        check_cmd("post_rst_pop", 3'd1, 32'h0, d_err);
`endif

        // Random commands against the queue model
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if      (r < 6)  op = 3'd0;
            else if (r < 9)  op = 3'd1;
            else if (r < 12) op = 3'd2;
            else if (r < 15) op = 3'd3;
            else if (r < 19) op = 3'd4;
            else             op = 3'($urandom_range(5, 7));
`ifndef OPSTACK_DEPTH_CHECK_EN
            if (ref_stk.size() < need_of(op))                 op = 3'd0;
            else if (grows_of(op) && ref_stk.size() >= 12)    op = 3'd1;
`endif
            check_cmd($sformatf("rnd%0d_op%0d", i, op), op, $urandom, d_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
